core_dispatch: RTL and testbench
================================

// Module: core_dispatch
// PURPOSE
//  Multi-thread successor to the single-thread core datapath. Accepts unit requests from
//  N_THREADS thread front-ends and grants them one at a time, round-robin. Each granted
//  request is routed to the shared ALU or to the memory port, and the result is returned
//  to the owning thread. The memory port has a ready handshake with wait states and a timeout.
// PARAMETERS
//  N_THREADS    4    number of requesting threads (>=1); TID_W = max(1,$clog2(N_THREADS))
//  WORD_W       32   data/address/ctrl width
//  MEM_TIMEOUT  255  max mem_req cycles without mem_ready before error; 0 disables timeout
// PORTS
//  clk           in   1            clock, all state on rising edge
//  rst           in   1            asynchronous reset, active-low
//  req_valid     in   N            per-thread request pending; held until that thread's rsp_valid
//  req_sel       in   2*N          per-thread unit_sel_t (ALU=0, MEM=1, others invalid)
//  req_ctrl      in   N*WORD_W     per-thread unit ctrl; for MEM, bit0 = write enable
//  req_in0       in   N*WORD_W     per-thread operand 0 (MEM: address)
//  req_in1       in   N*WORD_W     per-thread operand 1 (MEM: write data)
//  rsp_valid     out  N            one-cycle pulse to the owning thread; registered
//  rsp_err       out  1            error flag, qualified by rsp_valid
//  rsp_data      out  WORD_W       result, shared by all threads, qualified by rsp_valid
//  alu_ctrl      out  WORD_W       to external alu; 0 unless state==EXEC
//  alu_in0/1     out  WORD_W       latched operands, 0 unless state==EXEC
//  alu_out       in   WORD_W       combinational ALU result
//  mem_req       out  1            memory access request
//  mem_write_en  out  1            latched ctrl[0] while mem_req, else 0
//  mem_addr      out  WORD_W       latched in0 while mem_req, else 0
//  mem_din       out  WORD_W       latched in1 while mem_req, else 0
//  mem_ready     in   1            access complete this cycle
//  mem_dout      in   WORD_W       read data, valid with mem_ready
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rr_ptr=0, wait counter=0, all outputs 0; an in-flight
//   transaction is dropped and produces no response. mem_req falls immediately.
//  FSM states: IDLE, EXEC, MEM_REQ, RESP.
//  IDLE: req_valid is sampled only in this state. Grant = first set bit, searching from rr_ptr
//   upward with wrap. On grant, latch tid/sel/ctrl/in0/in1 and go to EXEC (ALU), MEM_REQ (MEM)
//   or RESP (invalid sel, err=1, data=0). With no request, stay in IDLE.
//  EXEC: drive the alu_* ports, capture alu_out into rsp_data, err=0, go to RESP.
//  MEM_REQ: mem_req=1. If mem_ready: capture mem_dout (0 for writes), err=0, go to RESP.
//   Otherwise increment the counter; if MEM_TIMEOUT!=0 and count reaches MEM_TIMEOUT, go to
//   RESP with err=1, data=0. mem_ready in the same cycle as the timeout: ready wins.
//  RESP: rsp_valid[tid]=1 for exactly this cycle; rr_ptr <= (tid+1) mod N_THREADS;
//   counter clears; go to IDLE. The thread drops req_valid at this edge; a req_valid still high
//   in the next IDLE cycle is a new request.
//  Latency (grant edge = t): invalid -> rsp at t+1; ALU -> rsp at t+2; MEM with k wait cycles
//   (ready in the (k+1)th MEM_REQ cycle) -> rsp at t+2+k. ALU throughput: 1 op per 3 cycles.
//  rsp_data and rsp_err hold their value until the next RESP. rsp_valid is one-hot or 0.
//  N_THREADS=1: rr_ptr stays 0.
// TESTING
//  1 ALU op: thread0 sel=ALU in0=5 in1=7, bench alu adds -> rsp_valid=4'b0001 at t+2,
//    rsp_data=12, err=0; alu_ctrl nonzero only in the EXEC cycle.
//  2 MEM write, 3 waits: thread2 sel=MEM ctrl=1 addr=0x100 din=0xDEAD, ready in 4th cycle ->
//    mem_req high 4 cycles, write_en=1, rsp_valid=4'b0100 at t+5, err=0.
//  3 RR fairness: all 4 threads request ALU continuously from rr_ptr=0 -> responses to threads
//    0,1,2,3,0 spaced 3 cycles apart; then drop thread1 -> order 2,3,0,2.
//  4 Timeout: MEM_TIMEOUT=8, mem_ready held 0 -> mem_req high 8 cycles, then rsp err=1 data=0.
//    Repeat with ready asserted in the 8th cycle -> err=0, data=mem_dout.
//  5 Invalid sel=3 on thread3 -> rsp_valid=4'b1000 at t+1, err=1, data=0; no alu/mem activity.
//  6 Reset mid MEM_REQ: drop rst in cycle 2 of a wait -> mem_req=0 asynchronously, no rsp.
//    After release: IDLE, and a pending thread1 request is granted first (rr_ptr=0 searched).

Source files
------------

// File: rtl/core_dispatch_if.sv
// Bundles the thread request/response, ALU and memory buses of core_dispatch.
// The slave side is the dispatcher. The master side is the thread front-ends together with the ALU and the memory.
interface core_dispatch_if #(
  parameter int N_THREADS = 4,
  parameter int WORD_W    = 32
);
  logic [N_THREADS-1:0]        req_valid;
  logic [2*N_THREADS-1:0]      req_sel;
  logic [N_THREADS*WORD_W-1:0] req_ctrl;
  logic [N_THREADS*WORD_W-1:0] req_in0;
  logic [N_THREADS*WORD_W-1:0] req_in1;
  logic [N_THREADS-1:0]        rsp_valid;
  logic                        rsp_err;
  logic [WORD_W-1:0]           rsp_data;
  logic [WORD_W-1:0]           alu_ctrl;
  logic [WORD_W-1:0]           alu_in0;
  logic [WORD_W-1:0]           alu_in1;
  logic [WORD_W-1:0]           alu_out;
  logic                        mem_req;
  logic                        mem_write_en;
  logic [WORD_W-1:0]           mem_addr;
  logic [WORD_W-1:0]           mem_din;
  logic                        mem_ready;
  logic [WORD_W-1:0]           mem_dout;

  modport master (
    output req_valid, req_sel, req_ctrl, req_in0, req_in1, alu_out, mem_ready, mem_dout,
    input  rsp_valid, rsp_err, rsp_data, alu_ctrl, alu_in0, alu_in1,
           mem_req, mem_write_en, mem_addr, mem_din
  );

  modport slave (
    input  req_valid, req_sel, req_ctrl, req_in0, req_in1, alu_out, mem_ready, mem_dout,
    output rsp_valid, rsp_err, rsp_data, alu_ctrl, alu_in0, alu_in1,
           mem_req, mem_write_en, mem_addr, mem_din
  );
endinterface

// File: rtl/core_dispatch.sv
// Round-robin dispatcher: grants one thread request at a time and routes it to the shared ALU or the memory port.
// Memory accesses have wait states and an optional timeout. The result is returned to the thread that made the request.
module core_dispatch #(
  parameter int N_THREADS   = 4,
  parameter int WORD_W      = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  core_dispatch_if.slave bus
);
  localparam int TID_W = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;
  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;

  typedef enum logic [1:0] {IDLE, EXEC, MEM_REQ, RESP} state_t;

  state_t               state_reg, state_next;
  logic [TID_W-1:0]     rr_ptr_reg, rr_next;
  logic [TID_W-1:0]     tid_reg, tid_next;
  logic [WORD_W-1:0]    ctrl_reg, in0_reg, in1_reg;
  logic [CNT_W-1:0]     cnt_reg, cnt_inc;
  logic [N_THREADS-1:0] rsp_valid_reg, rsp_valid_next;
  logic                 rsp_err_reg;
  logic [WORD_W-1:0]    rsp_data_reg;
  logic                 grant_found;
  logic [TID_W-1:0]     grant_tid;
  logic                 timeout_hit;
  int                   scan_idx;

  logic [1:0]        sel_arr  [N_THREADS];
  logic [WORD_W-1:0] ctrl_arr [N_THREADS];
  logic [WORD_W-1:0] in0_arr  [N_THREADS];
  logic [WORD_W-1:0] in1_arr  [N_THREADS];

  generate
    for (genvar gi = 0; gi < N_THREADS; gi++) begin : g_thread
      assign sel_arr[gi]        = bus.req_sel[2*gi +: 2];
      assign ctrl_arr[gi]       = bus.req_ctrl[gi*WORD_W +: WORD_W];
      assign in0_arr[gi]        = bus.req_in0[gi*WORD_W +: WORD_W];
      assign in1_arr[gi]        = bus.req_in1[gi*WORD_W +: WORD_W];
      assign rsp_valid_next[gi] = (state_next == RESP) && (tid_next == TID_W'(gi));
    end
  endgenerate

  // Scan downward so that the last hit is the first requester at or above rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_tid   = '0;
    scan_idx    = 0;
    for (int i = N_THREADS - 1; i >= 0; i--) begin
      scan_idx = int'(rr_ptr_reg) + i;
      if (scan_idx >= N_THREADS) scan_idx = scan_idx - N_THREADS;
      if (bus.req_valid[TID_W'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_tid   = TID_W'(scan_idx);
      end
    end
  end

  assign tid_next    = (state_reg == IDLE) ? grant_tid : tid_reg;
  assign rr_next     = (tid_reg == TID_W'(N_THREADS - 1)) ? '0 : tid_reg + 1'b1;
  assign cnt_inc     = cnt_reg + 1'b1;
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_inc == TIMEOUT_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          case (sel_arr[grant_tid])
            SEL_ALU: state_next = EXEC;
            SEL_MEM: state_next = MEM_REQ;
            default: state_next = RESP;
          endcase
        end
      end
      EXEC:    state_next = RESP;
      MEM_REQ: if (bus.mem_ready || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode the registered state only, so mem_req drops as soon as reset asserts.
  always_comb begin
    bus.alu_ctrl     = '0;
    bus.alu_in0      = '0;
    bus.alu_in1      = '0;
    bus.mem_req      = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_din      = '0;
    case (state_reg)
      EXEC: begin
        bus.alu_ctrl = ctrl_reg;
        bus.alu_in0  = in0_reg;
        bus.alu_in1  = in1_reg;
      end
      MEM_REQ: begin
        bus.mem_req      = 1'b1;
        bus.mem_write_en = ctrl_reg[0];
        bus.mem_addr     = in0_reg;
        bus.mem_din      = in1_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg    <= '0;
      tid_reg       <= '0;
      ctrl_reg      <= '0;
      in0_reg       <= '0;
      in1_reg       <= '0;
      cnt_reg       <= '0;
      rsp_valid_reg <= '0;
      rsp_err_reg   <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            tid_reg  <= grant_tid;
            ctrl_reg <= ctrl_arr[grant_tid];
            in0_reg  <= in0_arr[grant_tid];
            in1_reg  <= in1_arr[grant_tid];
            if (sel_arr[grant_tid] != SEL_ALU && sel_arr[grant_tid] != SEL_MEM) begin
              rsp_err_reg  <= 1'b1;
              rsp_data_reg <= '0;
            end
          end
        end
        EXEC: begin
          rsp_data_reg <= bus.alu_out;
          rsp_err_reg  <= 1'b0;
        end
        MEM_REQ: begin
          if (bus.mem_ready) begin
            rsp_data_reg <= ctrl_reg[0] ? '0 : bus.mem_dout;
            rsp_err_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_inc;
            if (timeout_hit) begin
              rsp_data_reg <= '0;
              rsp_err_reg  <= 1'b1;
            end
          end
        end
        RESP: begin
          rr_ptr_reg <= rr_next;
          cnt_reg    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_data  = rsp_data_reg;
endmodule

// File: tb/tb_core_dispatch.sv
// Randomized and directed bench for core_dispatch against a transaction-level model.
// The model covers round-robin order, per-unit latency, memory timeout and response data.
module tb_core_dispatch;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  core_dispatch_if #(.N_THREADS(N), .WORD_W(W)) bus ();

  core_dispatch #(.N_THREADS(N), .WORD_W(W), .MEM_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] memf(input logic [W-1:0] a);
    return (a ^ 32'h5A5A_C3C3) + 32'h0000_1234;
  endfunction

  // External ALU and memory models. The memory asserts ready after cur_wait wait cycles.
  int cur_wait = 0;
  int mem_cnt  = 0;
  always @(posedge clk) mem_cnt <= bus.mem_req ? mem_cnt + 1 : 0;
  assign bus.alu_out   = bus.alu_ctrl[0] ? bus.alu_in0 + bus.alu_in1 : bus.alu_in0 ^ bus.alu_in1;
  assign bus.mem_ready = bus.mem_req && (mem_cnt == cur_wait);
  assign bus.mem_dout  = bus.mem_ready ? memf(bus.mem_addr) : 32'hDEAD_BEEF;

  // Per-thread request descriptors and the round-robin model.
  logic [1:0]   d_sel  [N];
  logic [W-1:0] d_ctrl [N];
  logic [W-1:0] d_in0  [N];
  logic [W-1:0] d_in1  [N];
  int           d_wait [N];
  bit           pend   [N];
  int           rr_m = 0;
  int           reissue_left = 0;

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]          = pend[i];
      bus.req_sel[2*i +: 2]     = d_sel[i];
      bus.req_ctrl[i*W +: W]    = d_ctrl[i];
      bus.req_in0[i*W +: W]     = d_in0[i];
      bus.req_in1[i*W +: W]     = d_in1[i];
    end
  endtask

  task automatic set_desc(input int t, input logic [1:0] s, input logic [W-1:0] c,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    d_sel[t] = s; d_ctrl[t] = c; d_in0[t] = a; d_in1[t] = b; d_wait[t] = k;
  endtask

  task automatic rand_desc(input int t);
    int r;
    logic [1:0] s;
    r = $urandom_range(0, 9);
    s = (r < 5) ? 2'd0 : (r < 9) ? 2'd1 : 2'($urandom_range(2, 3));
    set_desc(t, s, $urandom, $urandom, $urandom, $urandom_range(0, TO + 1));
  endtask

  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      if (pend[(rr_m + i) % N]) return (rr_m + i) % N;
    end
    return -1;
  endfunction

  // Serves every pending request. Call at a negedge while the DUT is idle.
  task automatic run_round();
    int  t, lat, expw, exp_m, exp_a, waited, mcnt, acnt;
    bit  first, got, mbad, abad, exp_err, is_mem_ok;
    logic [W-1:0] exp_data;
    first = 1'b1;
    t = pick();
    while (t >= 0) begin
      exp_m = 0; exp_a = 0; exp_err = 1'b0; exp_data = '0;
      if (d_sel[t] == 2'd0) begin
        lat = 2;
        exp_a = ((d_ctrl[t] | d_in0[t] | d_in1[t]) != 0) ? 1 : 0;
        exp_data = d_ctrl[t][0] ? d_in0[t] + d_in1[t] : d_in0[t] ^ d_in1[t];
      end else if (d_sel[t] == 2'd1) begin
        is_mem_ok = d_wait[t] < TO;
        lat   = is_mem_ok ? d_wait[t] + 2 : TO + 1;
        exp_m = is_mem_ok ? d_wait[t] + 1 : TO;
        exp_err  = !is_mem_ok;
        exp_data = (is_mem_ok && !d_ctrl[t][0]) ? memf(d_in0[t]) : '0;
      end else begin
        lat = 1;
        exp_err = 1'b1;
      end
      expw = first ? lat : lat + 1;
      cur_wait = d_wait[t];
      waited = 0; got = 1'b0; mcnt = 0; acnt = 0; mbad = 1'b0; abad = 1'b0;
      while (!got && waited < expw + 4) begin
        @(negedge clk);
        waited++;
        if (bus.mem_req) begin
          mcnt++;
          if (bus.mem_addr !== d_in0[t] || bus.mem_din !== d_in1[t] ||
              bus.mem_write_en !== d_ctrl[t][0]) mbad = 1'b1;
        end else if (bus.mem_write_en || bus.mem_addr != 0 || bus.mem_din != 0) begin
          mbad = 1'b1;
        end
        if ((bus.alu_ctrl | bus.alu_in0 | bus.alu_in1) != 0) begin
          acnt++;
          if (bus.alu_ctrl !== d_ctrl[t] || bus.alu_in0 !== d_in0[t] ||
              bus.alu_in1 !== d_in1[t]) abad = 1'b1;
        end
        if (bus.rsp_valid != 0) got = 1'b1;
      end
      $display("txn thread=%0d sel=%0d wait=%0d rsp_valid=%b err=%0b data=%08h cycles=%0d",
               t, d_sel[t], d_wait[t], bus.rsp_valid, bus.rsp_err, bus.rsp_data, waited);
      check_eq("rsp_time",   64'(waited), 64'(expw));
      check_eq("rsp_valid",  64'(bus.rsp_valid), 64'(1) << t);
      check_eq("rsp_err",    64'(bus.rsp_err), 64'(exp_err));
      check_eq("rsp_data",   64'(bus.rsp_data), 64'(exp_data));
      check_eq("mem_cycles", 64'(mcnt), 64'(exp_m));
      check_eq("mem_fields", 64'(mbad), 64'(0));
      check_eq("alu_cycles", 64'(acnt), 64'(exp_a));
      check_eq("alu_fields", 64'(abad), 64'(0));
      pend[t] = 1'b0;
      rr_m = (t + 1) % N;
      if (reissue_left > 0 && $urandom_range(0, 1) == 1) begin
        rand_desc(t);
        pend[t] = 1'b1;
        reissue_left--;
      end
      drive_reqs();
      first = 1'b0;
      t = pick();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      set_desc(i, 2'd0, '0, '0, '0, 0);
    end
    drive_reqs();
    repeat (2) @(negedge clk);
    check_eq("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check_eq("reset_rsp_data",  64'(bus.rsp_data), 64'(0));
    check_eq("reset_mem_req",   64'(bus.mem_req), 64'(0));
    check_eq("reset_alu_ctrl",  64'(bus.alu_ctrl), 64'(0));
    rst = 1'b1;
    @(negedge clk);

    // ALU add on thread 0
    set_desc(0, 2'd0, 32'd1, 32'd5, 32'd7, 0); pend[0] = 1'b1;
    drive_reqs(); run_round();
    check_eq("alu_sum", 64'(bus.rsp_data), 64'd12);

    // Memory write on thread 2 with three wait cycles
    @(negedge clk);
    set_desc(2, 2'd1, 32'd1, 32'h100, 32'hDEAD, 3); pend[2] = 1'b1;
    drive_reqs(); run_round();

    // Timeout on thread 0, then ready arriving in the final allowed cycle
    @(negedge clk);
    set_desc(0, 2'd1, 32'd0, 32'h40, 32'h0, TO); pend[0] = 1'b1;
    drive_reqs(); run_round();
    @(negedge clk);
    set_desc(0, 2'd1, 32'd0, 32'h44, 32'h0, TO - 1); pend[0] = 1'b1;
    drive_reqs(); run_round();

    // Invalid unit select on thread 3
    @(negedge clk);
    set_desc(3, 2'd3, $urandom, $urandom, $urandom, 0); pend[3] = 1'b1;
    drive_reqs(); run_round();

    // All four threads compete for the ALU
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      set_desc(i, 2'd0, 32'd1, 32'(i), 32'(10 * i + 1), 0);
      pend[i] = 1'b1;
    end
    drive_reqs(); run_round();

    // Randomized rounds with reissued requests
    for (int r = 0; r < 40; r++) begin
      int mask;
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
      mask = $urandom_range(1, (1 << N) - 1);
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          rand_desc(i);
          pend[i] = 1'b1;
        end
      end
      reissue_left = $urandom_range(0, 3);
      drive_reqs(); run_round();
    end
    reissue_left = 0;

    // Reset during a memory wait: no response, and the arbiter restarts from thread 0
    @(negedge clk);
    set_desc(1, 2'd0, 32'd1, 32'd2, 32'd3, 0); pend[1] = 1'b1;
    drive_reqs(); run_round();
    @(negedge clk);
    set_desc(2, 2'd1, 32'd0, 32'h200, 32'h0, 20); pend[2] = 1'b1;
    cur_wait = 20;
    drive_reqs();
    repeat (2) @(negedge clk);
    check_eq("pre_reset_mem_req", 64'(bus.mem_req), 64'd1);
    #1 rst = 1'b0;
    #1;
    check_eq("async_mem_req",   64'(bus.mem_req), 64'd0);
    check_eq("async_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    pend[2] = 1'b0;
    set_desc(1, 2'd0, 32'd1, 32'd20, 32'd22, 0); pend[1] = 1'b1;
    set_desc(3, 2'd0, 32'd0, 32'hF0, 32'h0F, 0); pend[3] = 1'b1;
    drive_reqs();
    repeat (2) begin
      @(negedge clk);
      check_eq("in_reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    end
    rst = 1'b1;
    rr_m = 0;
    run_round();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
